// File: rtl/hamming_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_encoder_seq
//  Description : Sequential Hamming(16,11) SECDED encoder. Walks NUM_WORDS
//                11-bit words stored as byte pairs in data memory. It
//                computes p8/p4/p2/p1 plus the overall parity p0 for each
//                word and writes the 16-bit codeword back as two bytes.
//                Optional build macro HAMMING_ERR_INJECT_EN adds inj_en and
//                inj_pos. These flip one codeword bit for decoder test vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_encoder_seq #(
    parameter int NUM_WORDS = 15,   // words to encode, 1..127
    parameter int IN_BASE   = 0,    // byte address of first input word
    parameter int OUT_BASE  = 30,   // byte address of first output codeword
    parameter int AW        = 8     // memory address width
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic          inj_en,
    input  logic [3:0]    inj_pos,
`endif
    output logic [AW-1:0] mem_raddr,
    input  logic [7:0]    mem_rdata,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          mem_wen,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_ENC   = 3'd3,
        ST_WR_LO = 3'd4,
        ST_WR_HI = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Base addresses pre-folded with the +1 of the high byte so the datapath
    // only needs one adder per address; truncation gives the modulo-2^AW wrap.
    localparam logic [AW-1:0] c_in_lo  = AW'(IN_BASE);
    localparam logic [AW-1:0] c_in_hi  = AW'(IN_BASE + 1);
    localparam logic [AW-1:0] c_out_lo = AW'(OUT_BASE);
    localparam logic [AW-1:0] c_out_hi = AW'(OUT_BASE + 1);
    localparam logic [6:0]    c_last   = 7'(NUM_WORDS - 1);

    state_t      state_q, state_d;
    logic [6:0]  i_q, i_d;          // current word index
    logic [7:0]  lo_q, lo_d;        // b8..b1 of the current word
    logic [15:0] cw_q, cw_d;        // registered codeword for the write phases

    logic [AW-1:0] w_off;
    logic [10:0]   w_data;          // w_data[n-1] holds data bit bn
    logic          w_p8, w_p4, w_p2, w_p1, w_p0;
    logic [14:0]   w_cw_hi15;
    logic [15:0]   w_cw_clean;
    logic [15:0]   w_cw;

    // Byte offset of word i inside either region (two bytes per word).
    assign w_off = AW'({i_q, 1'b0});

    // Parity generation: the high data bits come straight off the read port in ENC.
    assign w_data = {mem_rdata[2:0], lo_q};
    assign w_p8   = ^w_data[10:4];
    assign w_p4   = w_data[10] ^ w_data[9] ^ w_data[8] ^ w_data[7]
                  ^ w_data[3]  ^ w_data[2] ^ w_data[1];
    assign w_p2   = w_data[10] ^ w_data[9] ^ w_data[6] ^ w_data[5]
                  ^ w_data[3]  ^ w_data[2] ^ w_data[0];
    assign w_p1   = w_data[10] ^ w_data[8] ^ w_data[6] ^ w_data[4]
                  ^ w_data[3]  ^ w_data[1] ^ w_data[0];

    // Codeword bits 15..1: MSW = {b11..b5,p8}, LSW[7:1] = {b4,b3,b2,p4,b1,p2,p1}
    assign w_cw_hi15  = {w_data[10:4], w_p8, w_data[3:1], w_p4, w_data[0], w_p2, w_p1};
    assign w_p0       = ^w_cw_hi15;
    assign w_cw_clean = {w_cw_hi15, w_p0};

`ifdef HAMMING_ERR_INJECT_EN
    // Single-bit corruption is applied after parity so the result is a
    // genuine one-bit error relative to a valid codeword.
    assign w_cw = w_cw_clean ^ (inj_en ? (16'd1 << inj_pos) : 16'd0);
`else
    assign w_cw = w_cw_clean;
`endif

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            i_q     <= 7'd0;
            lo_q    <= 8'd0;
            cw_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            lo_q    <= lo_d;
            cw_q    <= cw_d;
        end
    end

    // Next-state logic and memory-port decode, all from state and registers.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        lo_d      = lo_q;
        cw_d      = cw_q;
        mem_raddr = '0;
        mem_waddr = '0;
        mem_wdata = 8'd0;
        mem_wen   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                mem_raddr = c_in_lo + w_off;
                state_d   = ST_RD_HI;
            end
            ST_RD_HI: begin
                lo_d      = mem_rdata;
                mem_raddr = c_in_hi + w_off;
                state_d   = ST_ENC;
            end
            ST_ENC: begin
                cw_d    = w_cw;
                state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                mem_wen   = 1'b1;
                mem_waddr = c_out_lo + w_off;
                mem_wdata = cw_q[7:0];
                state_d   = ST_WR_HI;
            end
            ST_WR_HI: begin
                mem_wen   = 1'b1;
                mem_waddr = c_out_hi + w_off;
                mem_wdata = cw_q[15:8];
                if (i_q == c_last) begin
                    i_d     = 7'd0;
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 7'd1;
                    state_d = ST_RD_LO;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_encoder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_encoder_seq
//  Description : Self-checking bench for hamming_encoder_seq. Runs two
//                instances, with one word and fifteen words, on byte-wide
//                registered memories. A cycle-level reference model derives
//                every expected output from the word timeline and the
//                encoding rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_encoder_seq;

    localparam int IN  = 0;
    localparam int OUT = 30;
    localparam int AW  = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          rst   [2];
    logic          st    [2];
    logic [AW-1:0] raddr [2];
    logic [AW-1:0] waddr [2];
    logic [7:0]    rdata [2];
    logic [7:0]    wdata [2];
    logic          wen   [2];
    logic          busy  [2];
    logic          done  [2];
`ifdef HAMMING_ERR_INJECT_EN
    logic          inj_en  [2];
    logic [3:0]    inj_pos [2];
`endif

    logic [7:0] mem [2][256];
    logic [7:0] din [2][256];     // bench copy of all input bytes loaded
    logic       ld_we;
    int         ld_sel;
    int         ld_addr;
    logic [7:0] ld_data;

    int checks;
    int failures;
    int wen_cnt;
    int done_cnt;

    hamming_encoder_seq #(.NUM_WORDS(1), .IN_BASE(IN), .OUT_BASE(OUT), .AW(AW)) u_dut1 (
        .Clk(Clk), .Reset(rst[0]), .start(st[0]),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_en(inj_en[0]), .inj_pos(inj_pos[0]),
`endif
        .mem_raddr(raddr[0]), .mem_rdata(rdata[0]), .mem_waddr(waddr[0]),
        .mem_wdata(wdata[0]), .mem_wen(wen[0]), .busy(busy[0]), .done(done[0])
    );

    hamming_encoder_seq #(.NUM_WORDS(15), .IN_BASE(IN), .OUT_BASE(OUT), .AW(AW)) u_dut15 (
        .Clk(Clk), .Reset(rst[1]), .start(st[1]),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_en(inj_en[1]), .inj_pos(inj_pos[1]),
`endif
        .mem_raddr(raddr[1]), .mem_rdata(rdata[1]), .mem_waddr(waddr[1]),
        .mem_wdata(wdata[1]), .mem_wen(wen[1]), .busy(busy[1]), .done(done[1])
    );

    // Registered memories: read data valid one cycle after the address.
    always @(posedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            rdata[d] <= mem[d][raddr[d]];
            if (ld_we && ld_sel == d) mem[d][ld_addr] <= ld_data;
            else if (wen[d])          mem[d][waddr[d]] <= wdata[d];
        end
    end

    function automatic int nwords(input int d);
        return (d == 0) ? 1 : 15;
    endfunction

    // Reference encoder written directly from the bit-numbered parity rules.
    function automatic logic [15:0] encode(input logic [7:0] lo, input logic [7:0] hi);
        logic [11:1] b;
        logic        p8, p4, p2, p1, p0;
        logic [7:0]  msw;
        logic [6:0]  lsw7;
        b    = {hi[2:0], lo};
        p8   = b[11] ^ b[10] ^ b[9] ^ b[8] ^ b[7] ^ b[6] ^ b[5];
        p4   = b[11] ^ b[10] ^ b[9] ^ b[8] ^ b[4] ^ b[3] ^ b[2];
        p2   = b[11] ^ b[10] ^ b[7] ^ b[6] ^ b[4] ^ b[3] ^ b[1];
        p1   = b[11] ^ b[9]  ^ b[7] ^ b[5] ^ b[4] ^ b[2] ^ b[1];
        msw  = {b[11], b[10], b[9], b[8], b[7], b[6], b[5], p8};
        lsw7 = {b[4], b[3], b[2], p4, b[1], p2, p1};
        p0   = ($countones({msw, lsw7}) % 2) == 1;
        return {msw, lsw7, p0};
    endfunction

    // Run timeline: act = a run is in progress, kk = cycle number since the
    // edge that sampled start (1 = first read cycle, 5*N+1 = done cycle).
    logic act [2];
    int   kk  [2];
    always @(posedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                act[d] <= 1'b0;
                kk[d]  <= 0;
            end else if (act[d]) begin
                if (kk[d] == 5 * nwords(d) + 1) act[d] <= 1'b0;
                else                             kk[d]  <= kk[d] + 1;
            end else if (st[d]) begin
                act[d] <= 1'b1;
                kk[d]  <= 1;
            end
        end
    end

    // Expected {busy,done,wen,waddr,wdata,raddr} for the current cycle.
    function automatic logic [26:0] expect_out(input int d);
        int          w;
        int          ph;
        logic [15:0] cw;
        logic [7:0]  ra, wa, wd;
        logic        we, bz, dn;
        ra = 8'd0; wa = 8'd0; wd = 8'd0; we = 1'b0; bz = 1'b0; dn = 1'b0;
        if (act[d] === 1'b1) begin
            bz = 1'b1;
            if (kk[d] == 5 * nwords(d) + 1) begin
                dn = 1'b1;
            end else begin
                w  = (kk[d] - 1) / 5;
                ph = (kk[d] - 1) % 5;
                cw = encode(din[d][IN + 2*w], din[d][IN + 2*w + 1]);
                case (ph)
                    0: ra = 8'(IN + 2*w);
                    1: ra = 8'(IN + 2*w + 1);
                    3: begin we = 1'b1; wa = 8'(OUT + 2*w);     wd = cw[7:0];  end
                    4: begin we = 1'b1; wa = 8'(OUT + 2*w + 1); wd = cw[15:8]; end
                    default: ;
                endcase
            end
        end
        return {bz, dn, we, wa, wd, ra};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic cycle_compare();
        logic [26:0] e, o;
        for (int d = 0; d < 2; d++) begin
            e = expect_out(d);
            o = {busy[d], done[d], wen[d], waddr[d], wdata[d], raddr[d]};
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL cycle dut%0d k=%0d got=%h want=%h (busy,done,wen,waddr,wdata,raddr)",
                         d, kk[d], o, e);
            end
        end
        if (wen[1])  wen_cnt++;
        if (done[1]) done_cnt++;
    endtask

    task automatic load(input int d, input int a, input logic [7:0] v);
        @(negedge Clk);
        ld_sel  = d;
        ld_addr = a;
        ld_data = v;
        ld_we   = 1'b1;
        din[d][a] = v;
        @(negedge Clk);
        ld_we = 1'b0;
    endtask

    // Pulse start, return the cycle count (after the sampling edge) at which
    // done is seen. The 15-word instance also gets start pulses while busy
    // and one in its DONE cycle, all of which must be ignored.
    task automatic run(input int d, input int limit, output int n);
        @(negedge Clk);
        st[d] = 1'b1;
        @(posedge Clk);
        n = 0;
        while (n < limit) begin
            @(negedge Clk);
            n++;
            if (done[d]) begin
                st[d] = (d == 1);
                break;
            end
            st[d] = (d == 1) && (n % 7 == 3) && (n < 70);
        end
        @(negedge Clk);
        st[d] = 1'b0;
    endtask

    logic [7:0] vlo [5] = '{8'h00, 8'hFF, 8'h01, 8'h00, 8'h00};
    logic [7:0] vhi [5] = '{8'h00, 8'h07, 8'h00, 8'h04, 8'hFC};
    logic [7:0] elo [5] = '{8'h00, 8'hFF, 8'h0F, 8'h17, 8'h17};
    logic [7:0] ehi [5] = '{8'h00, 8'hFF, 8'h00, 8'h81, 8'h81};

    initial begin
        int          n;
        logic [15:0] cw;
        checks   = 0;
        failures = 0;
        wen_cnt  = 0;
        done_cnt = 0;
        ld_we    = 1'b0;
        ld_sel   = 0;
        ld_addr  = 0;
        ld_data  = 8'd0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            st[d]  = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
            inj_en[d]  = 1'b0;
            inj_pos[d] = 4'd0;
`endif
        end
        repeat (3) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_outs dut%0d", d),
                {28'd0, busy[d], done[d], wen[d], 1'b0}, 32'd0);
            chk($sformatf("reset_addr dut%0d", d), {16'd0, raddr[d], waddr[d]}, 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        fork
            forever begin
                @(negedge Clk);
                cycle_compare();
            end
        join_none

        // Directed single-word vectors with hand-computed codewords.
        for (int t = 0; t < 5; t++) begin
            load(0, 30, 8'h5A);
            load(0, 31, 8'hA5);
            load(0, 0, vlo[t]);
            load(0, 1, vhi[t]);
            chk($sformatf("model_pin v%0d", t), {16'd0, encode(vlo[t], vhi[t])},
                {16'd0, ehi[t], elo[t]});
            run(0, 30, n);
            chk($sformatf("done_latency_n1 v%0d", t), n, 6);
            chk($sformatf("lsw@30 v%0d", t), {24'd0, mem[0][30]}, {24'd0, elo[t]});
            chk($sformatf("msw@31 v%0d", t), {24'd0, mem[0][31]}, {24'd0, ehi[t]});
        end

        // Fifteen random words, upper bits of the high byte randomised too.
        for (int j = 0; j < 30; j++) load(1, IN + j, 8'($urandom));
        @(negedge Clk);
        wen_cnt  = 0;
        done_cnt = 0;
        run(1, 200, n);
        chk("done_latency_n15", n, 76);
        @(negedge Clk);
        chk("start_in_done_ignored_a", {31'd0, busy[1]}, 32'd0);
        @(negedge Clk);
        chk("start_in_done_ignored_b", {31'd0, busy[1]}, 32'd0);
        chk("wen_cycles_n15", wen_cnt, 30);
        chk("done_pulses_n15", done_cnt, 1);
        for (int w = 0; w < 15; w++) begin
            cw = encode(din[1][IN + 2*w], din[1][IN + 2*w + 1]);
            chk($sformatf("rand_lsw w%0d", w), {24'd0, mem[1][OUT + 2*w]},     {24'd0, cw[7:0]});
            chk($sformatf("rand_msw w%0d", w), {24'd0, mem[1][OUT + 2*w + 1]}, {24'd0, cw[15:8]});
        end

        // Reset held three cycles starting in WR_LO of word 2.
        load(1, OUT + 4, 8'hA5);
        load(1, OUT + 5, 8'hA5);
        @(negedge Clk);
        st[1] = 1'b1;
        @(negedge Clk);
        st[1] = 1'b0;
        repeat (13) @(negedge Clk);
        chk("wr_lo_word2_reached", {23'd0, wen[1], waddr[1]}, {23'd0, 1'b1, 8'(OUT + 4)});
        rst[1] = 1'b1;
        @(negedge Clk);
        chk("reset_abort_busy", {31'd0, busy[1]}, 32'd0);
        chk("reset_abort_wen", {31'd0, wen[1]}, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        rst[1] = 1'b0;
        repeat (3) @(negedge Clk);
        chk("after_reset_idle", {31'd0, busy[1]}, 32'd0);
        chk("no_write_out5", {24'd0, mem[1][OUT + 5]}, 32'h0000_00A5);
        cw = encode(din[1][IN + 4], din[1][IN + 5]);
        chk("partial_out4_kept", {24'd0, mem[1][OUT + 4]}, {24'd0, cw[7:0]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
